// File: rtl/rd_decoder_pkg.sv
// rtl/rd_decoder_pkg.sv - shared encodings, opcodes and helpers for rd_decoder_pipe
// Contents:
//   fmt_e        instruction format classes as presented on the fmt output
//   OP_*         opcode constants, grouped by the ibus slice they compare against
//   *_LSB        bit positions of the register fields inside the instruction word
//   onehot()     index -> one-hot vector, sized for the widest supported REG_W
package rd_decoder_pkg;

  localparam int MAX_REG_W = 8;
  localparam int MAX_NREGS = 2 ** MAX_REG_W;

  typedef enum logic [2:0] {
    FMT_NONE    = 3'd0,
    FMT_R       = 3'd1,
    FMT_I       = 3'd2,
    FMT_D_LOAD  = 3'd3,
    FMT_D_STORE = 3'd4,
    FMT_CB      = 3'd5,
    FMT_IW      = 3'd6,
    FMT_B       = 3'd7
  } fmt_e;

  // Register field positions; every field is 5 bits wide in the instruction word
  localparam int FIELD_W = 5;
  localparam int RD_LSB  = 0;
  localparam int RN_LSB  = 5;
  localparam int RM_LSB  = 16;

  // R-format, compared against ibus[31:21]
  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_EOR = 11'b11001010000;
  localparam logic [10:0] OP_LSL = 11'b11010011011;
  localparam logic [10:0] OP_LSR = 11'b11010011010;

  // I-format, compared against ibus[31:22]
  localparam logic [9:0] OP_ADDI = 10'b1001000100;
  localparam logic [9:0] OP_SUBI = 10'b1101000100;
  localparam logic [9:0] OP_ANDI = 10'b1001001000;
  localparam logic [9:0] OP_ORRI = 10'b1011001000;
  localparam logic [9:0] OP_EORI = 10'b1101001000;

  // D-format, compared against ibus[31:21]
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // CB-format, compared against ibus[31:24]
  localparam logic [7:0] OP_CBZ  = 8'b10110100;
  localparam logic [7:0] OP_CBNZ = 8'b10110101;

  // IW-format, compared against ibus[31:23]
  localparam logic [8:0] OP_MOVZ = 9'b110100101;

  // B-format, compared against ibus[31:26]
  localparam logic [5:0] OP_B = 6'b000101;

  function automatic logic [MAX_NREGS-1:0] onehot(input logic [MAX_REG_W-1:0] index,
                                                   input logic en);
    onehot = '0;
    if (en) onehot[index] = 1'b1;
  endfunction

endpackage

// File: rtl/sel_delay_line.sv
// rtl/sel_delay_line.sv - stall-aware shift register of {valid, select} pairs
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset, clears every entry
//   stall      in   1 = every entry holds
//   in_valid   in   valid bit loaded into entry 0
//   in_data    in   WIDTH-bit select loaded into entry 0
//   out_valid  out  valid bit of the last entry
//   out_data   out  select of the last entry, forced to 0 when out_valid is 0
module sel_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else if (!stall) begin
      vld_q[0] <= in_valid;
      dat_q[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = vld_q[DEPTH-1] ? dat_q[DEPTH-1] : '0;

endmodule

// File: rtl/rd_decoder_pipe.sv
// rtl/rd_decoder_pipe.sv - LEGv8 register-select decoder with writeback delay line
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   ibus       in   32-bit instruction word from IF/ID
//   in_valid   in   ibus carries a real instruction
//   stall      in   hold decode register and delay line
//   flush      in   clear the decode register (delay line unaffected)
//   rd_sel     out  one-hot destination select, 0 if no write
//   rn_sel     out  one-hot source A select, 0 if unused
//   rm_sel     out  one-hot source B select, 0 if unused
//   fmt        out  format class (fmt_e encoding)
//   illegal    out  valid instruction matched no opcode
//   out_valid  out  decode outputs valid
//   wb_sel     out  rd_sel delayed WB_LAT unstalled cycles
//   wb_valid   out  wb_sel valid
module rd_decoder_pipe
  import rd_decoder_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int WB_LAT      = 3,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [31:0]             ibus,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [(1<<REG_W)-1:0]   rd_sel,
  output logic [(1<<REG_W)-1:0]   rn_sel,
  output logic [(1<<REG_W)-1:0]   rm_sel,
  output logic [2:0]              fmt,
  output logic                    illegal,
  output logic                    out_valid,
  output logic [(1<<REG_W)-1:0]   wb_sel,
  output logic                    wb_valid
);

  localparam int NREGS = 1 << REG_W;

  // Fields are taken from their 5-bit slots and zero-extended or truncated to REG_W
  logic [FIELD_W-1:0] rd_f, rn_f, rm_f;
  logic [REG_W-1:0]   rd_idx, rn_idx, rm_idx, src_b_idx;

  assign rd_f   = ibus[RD_LSB +: FIELD_W];
  assign rn_f   = ibus[RN_LSB +: FIELD_W];
  assign rm_f   = ibus[RM_LSB +: FIELD_W];
  assign rd_idx = REG_W'(rd_f);
  assign rn_idx = REG_W'(rn_f);
  assign rm_idx = REG_W'(rm_f);

  // Immediate/offset bits never influence register selection
  logic unused_imm;
  assign unused_imm = ^ibus[15:10];

  fmt_e dec_fmt;
  logic shamt_form;

  always_comb begin
    dec_fmt    = FMT_NONE;
    shamt_form = 1'b0;
    if (ibus[31:21] inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_LSL, OP_LSR}) begin
      dec_fmt    = FMT_R;
      shamt_form = (ibus[31:21] == OP_LSL) || (ibus[31:21] == OP_LSR);
    end else if (ibus[31:22] inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_EORI}) begin
      dec_fmt = FMT_I;
    end else if (ibus[31:21] == OP_LDUR) begin
      dec_fmt = FMT_D_LOAD;
    end else if (ibus[31:21] == OP_STUR) begin
      dec_fmt = FMT_D_STORE;
    end else if (ibus[31:24] inside {OP_CBZ, OP_CBNZ}) begin
      dec_fmt = FMT_CB;
    end else if (ibus[31:23] == OP_MOVZ) begin
      dec_fmt = FMT_IW;
    end else if (ibus[31:26] == OP_B) begin
      dec_fmt = FMT_B;
    end
  end

  logic rd_use, rn_use, rm_use, rd_is_zr;

  // Source B is Rm for R-format, but the Rt slot (bits 4:0) for stores and CB
  assign src_b_idx = (dec_fmt == FMT_R) ? rm_idx : rd_idx;
  assign rd_is_zr  = (ZERO_REG_EN != 0) && (&rd_idx);
  assign rd_use    = in_valid && !rd_is_zr &&
                     (dec_fmt inside {FMT_R, FMT_I, FMT_D_LOAD, FMT_IW});
  assign rn_use    = in_valid && (dec_fmt inside {FMT_R, FMT_I, FMT_D_LOAD, FMT_D_STORE});
  assign rm_use    = in_valid && (((dec_fmt == FMT_R) && !shamt_form) ||
                                  (dec_fmt inside {FMT_D_STORE, FMT_CB}));

  logic [NREGS-1:0] rd_nx, rn_nx, rm_nx;

  assign rd_nx = NREGS'(onehot(MAX_REG_W'(rd_idx), rd_use));
  assign rn_nx = NREGS'(onehot(MAX_REG_W'(rn_idx), rn_use));
  assign rm_nx = NREGS'(onehot(MAX_REG_W'(src_b_idx), rm_use));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      fmt       <= FMT_NONE;
      illegal   <= 1'b0;
      rd_sel    <= '0;
      rn_sel    <= '0;
      rm_sel    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      fmt       <= FMT_NONE;
      illegal   <= 1'b0;
      rd_sel    <= '0;
      rn_sel    <= '0;
      rm_sel    <= '0;
    end else if (!stall) begin
      out_valid <= in_valid;
      fmt       <= in_valid ? dec_fmt : FMT_NONE;
      illegal   <= in_valid && (dec_fmt == FMT_NONE);
      rd_sel    <= rd_nx;
      rn_sel    <= rn_nx;
      rm_sel    <= rm_nx;
    end
  end

  sel_delay_line #(
    .WIDTH (NREGS),
    .DEPTH (WB_LAT)
  ) u_wb_delay (
    .clk       (clk),
    .reset_n   (reset_n),
    .stall     (stall),
    .in_valid  (out_valid),
    .in_data   (rd_sel),
    .out_valid (wb_valid),
    .out_data  (wb_sel)
  );

endmodule

// File: tb/tb_rd_decoder_pipe.sv
// tb/tb_rd_decoder_pipe.sv - self-checking bench for rd_decoder_pipe
module tb_rd_decoder_pipe;

  localparam int REG_W  = 5;
  localparam int NREGS  = 32;
  localparam int WB_LAT = 3;
  localparam int NOPS   = 18;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [31:0] ibus = '0;
  logic in_valid = 1'b0, stall = 1'b0, flush = 1'b0;

  logic [NREGS-1:0] rd_sel, rn_sel, rm_sel, wb_sel;
  logic [2:0] fmt;
  logic illegal, out_valid, wb_valid;

  logic [NREGS-1:0] z_rd_sel, z_rn_sel, z_rm_sel, z_wb_sel;
  logic [2:0] z_fmt;
  logic z_illegal, z_out_valid, z_wb_valid;

  always #5 clk = ~clk;

  rd_decoder_pipe #(.REG_W(REG_W), .WB_LAT(WB_LAT), .ZERO_REG_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .ibus(ibus), .in_valid(in_valid),
    .stall(stall), .flush(flush), .rd_sel(rd_sel), .rn_sel(rn_sel),
    .rm_sel(rm_sel), .fmt(fmt), .illegal(illegal), .out_valid(out_valid),
    .wb_sel(wb_sel), .wb_valid(wb_valid)
  );

  rd_decoder_pipe #(.REG_W(REG_W), .WB_LAT(WB_LAT), .ZERO_REG_EN(0)) dut_z0 (
    .clk(clk), .reset_n(reset_n), .ibus(ibus), .in_valid(in_valid),
    .stall(stall), .flush(flush), .rd_sel(z_rd_sel), .rn_sel(z_rn_sel),
    .rm_sel(z_rm_sel), .fmt(z_fmt), .illegal(z_illegal), .out_valid(z_out_valid),
    .wb_sel(z_wb_sel), .wb_valid(z_wb_valid)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Opcode table: mask/value over ibus plus which register fields the format reads.
  // rm_kind: 0 none, 1 Rm slot, 2 Rt slot (bits 4:0)
  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] val;
    logic [2:0]  fmt;
    logic        rd_use;
    logic        rn_use;
    logic [1:0]  rm_kind;
  } op_t;

  op_t ops [NOPS];

  typedef struct packed {
    logic        valid;
    logic [31:0] rd;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [2:0]  fmt;
    logic        illegal;
  } dec_t;

  function automatic op_t mk(input logic [31:0] mask, input logic [31:0] val,
                             input logic [2:0] f, input logic rdu, input logic rnu,
                             input logic [1:0] rmk);
    op_t o;
    o.mask = mask; o.val = val; o.fmt = f;
    o.rd_use = rdu; o.rn_use = rnu; o.rm_kind = rmk;
    return o;
  endfunction

  function automatic dec_t ref_decode(input logic [31:0] ib, input logic v, input bit zr);
    dec_t d;
    int hit;
    int rd, rn, rm;
    d = '0;
    hit = -1;
    if (!v) return d;
    d.valid = 1'b1;
    for (int i = 0; i < NOPS; i++)
      if (hit < 0 && (ib & ops[i].mask) == ops[i].val) hit = i;
    if (hit < 0) begin
      d.illegal = 1'b1;
      return d;
    end
    rd = int'(ib[4:0]);
    rn = int'(ib[9:5]);
    rm = int'(ib[20:16]);
    d.fmt = ops[hit].fmt;
    if (ops[hit].rd_use && !(zr && rd == NREGS - 1)) d.rd = 32'd1 << rd;
    if (ops[hit].rn_use) d.rn = 32'd1 << rn;
    if (ops[hit].rm_kind == 2'd1) d.rm = 32'd1 << rm;
    if (ops[hit].rm_kind == 2'd2) d.rm = 32'd1 << rd;
    return d;
  endfunction

  // Model state: decoded word for each instance, and the history of {valid, rd_sel}
  // seen at each unstalled edge, newest first.
  dec_t m_dec;
  logic [31:0] m_rd0;
  logic [32:0] hist[$];

  task automatic model_reset();
    m_dec = '0;
    m_rd0 = '0;
    hist.delete();
    for (int i = 0; i < WB_LAT; i++) hist.push_back(33'd0);
  endtask

  task automatic step();
    dec_t t;
    @(posedge clk);
    if (!stall) begin
      hist.push_front({m_dec.valid, m_dec.rd});
      void'(hist.pop_back());
    end
    if (flush) begin
      m_dec = '0;
      m_rd0 = '0;
    end else if (!stall) begin
      m_dec = ref_decode(ibus, in_valid, 1'b1);
      t = ref_decode(ibus, in_valid, 1'b0);
      m_rd0 = t.rd;
    end
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    logic [32:0] w;
    w = hist[WB_LAT-1];
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_dec.valid));
    chk({tag, ".rd_sel"}, rd_sel, m_dec.rd);
    chk({tag, ".rn_sel"}, rn_sel, m_dec.rn);
    chk({tag, ".rm_sel"}, rm_sel, m_dec.rm);
    chk({tag, ".fmt"}, 32'(fmt), 32'(m_dec.fmt));
    chk({tag, ".illegal"}, 32'(illegal), 32'(m_dec.illegal));
    chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(w[32]));
    chk({tag, ".wb_sel"}, wb_sel, w[32] ? w[31:0] : 32'd0);
    chk({tag, ".z0_rd_sel"}, z_rd_sel, m_rd0);
  endtask

  typedef struct {
    logic [31:0] ib;
    logic        v;
    logic        ev;
    logic [31:0] rd, rn, rm, rd0;
    logic [2:0]  f;
    logic        ill;
  } vec_t;

  vec_t vecs [13];

  task automatic idle(input int n);
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    ops[0]  = mk(32'hFFE0_0000, {11'b10001011000, 21'd0}, 3'd1, 1, 1, 2'd1);
    ops[1]  = mk(32'hFFE0_0000, {11'b11001011000, 21'd0}, 3'd1, 1, 1, 2'd1);
    ops[2]  = mk(32'hFFE0_0000, {11'b10001010000, 21'd0}, 3'd1, 1, 1, 2'd1);
    ops[3]  = mk(32'hFFE0_0000, {11'b10101010000, 21'd0}, 3'd1, 1, 1, 2'd1);
    ops[4]  = mk(32'hFFE0_0000, {11'b11001010000, 21'd0}, 3'd1, 1, 1, 2'd1);
    ops[5]  = mk(32'hFFE0_0000, {11'b11010011011, 21'd0}, 3'd1, 1, 1, 2'd0);
    ops[6]  = mk(32'hFFE0_0000, {11'b11010011010, 21'd0}, 3'd1, 1, 1, 2'd0);
    ops[7]  = mk(32'hFFC0_0000, {10'b1001000100, 22'd0}, 3'd2, 1, 1, 2'd0);
    ops[8]  = mk(32'hFFC0_0000, {10'b1101000100, 22'd0}, 3'd2, 1, 1, 2'd0);
    ops[9]  = mk(32'hFFC0_0000, {10'b1001001000, 22'd0}, 3'd2, 1, 1, 2'd0);
    ops[10] = mk(32'hFFC0_0000, {10'b1011001000, 22'd0}, 3'd2, 1, 1, 2'd0);
    ops[11] = mk(32'hFFC0_0000, {10'b1101001000, 22'd0}, 3'd2, 1, 1, 2'd0);
    ops[12] = mk(32'hFFE0_0000, {11'b11111000010, 21'd0}, 3'd3, 1, 1, 2'd0);
    ops[13] = mk(32'hFFE0_0000, {11'b11111000000, 21'd0}, 3'd4, 0, 1, 2'd2);
    ops[14] = mk(32'hFF00_0000, {8'b10110100, 24'd0}, 3'd5, 0, 0, 2'd2);
    ops[15] = mk(32'hFF00_0000, {8'b10110101, 24'd0}, 3'd5, 0, 0, 2'd2);
    ops[16] = mk(32'hFF80_0000, {9'b110100101, 23'd0}, 3'd6, 1, 0, 2'd0);
    ops[17] = mk(32'hFC00_0000, {6'b000101, 26'd0}, 3'd7, 0, 0, 2'd0);

    //               ibus          v  ev  rd           rn           rm           rd0          f     ill
    vecs[0]  = '{32'h8B020023, 1, 1, 32'h8,        32'h2,       32'h4,       32'h8,        3'd1, 0}; // ADD X3,X1,X2
    vecs[1]  = '{32'hF8000045, 1, 1, 32'h0,        32'h4,       32'h20,      32'h0,        3'd4, 0}; // STUR X5,[X2]
    vecs[2]  = '{32'h8B02003F, 1, 1, 32'h0,        32'h2,       32'h4,       32'h80000000, 3'd1, 0}; // ADD XZR
    vecs[3]  = '{32'h910004A4, 1, 1, 32'h10,       32'h20,      32'h0,       32'h10,       3'd2, 0}; // ADDI X4,X5,#1
    vecs[4]  = '{32'hF8400127, 1, 1, 32'h80,       32'h200,     32'h0,       32'h80,       3'd3, 0}; // LDUR X7,[X9]
    vecs[5]  = '{32'hB4000006, 1, 1, 32'h0,        32'h0,       32'h40,      32'h0,        3'd5, 0}; // CBZ X6
    vecs[6]  = '{32'hB5000009, 1, 1, 32'h0,        32'h0,       32'h200,     32'h0,        3'd5, 0}; // CBNZ X9
    vecs[7]  = '{32'hD2800008, 1, 1, 32'h100,      32'h0,       32'h0,       32'h100,      3'd6, 0}; // MOVZ X8
    vecs[8]  = '{32'h14000123, 1, 1, 32'h0,        32'h0,       32'h0,       32'h0,        3'd7, 0}; // B
    vecs[9]  = '{32'hD3630022, 1, 1, 32'h4,        32'h2,       32'h0,       32'h4,        3'd1, 0}; // LSL, rm field ignored
    vecs[10] = '{32'hFFFFFFFF, 1, 1, 32'h0,        32'h0,       32'h0,       32'h0,        3'd0, 1}; // illegal
    vecs[11] = '{32'h8B020023, 0, 0, 32'h0,        32'h0,       32'h0,       32'h0,        3'd0, 0}; // bubble
    vecs[12] = '{32'hCB1F03FF, 1, 1, 32'h0,        32'h80000000, 32'h80000000, 32'h80000000, 3'd1, 0}; // SUB XZR,XZR,XZR

    // Reset state
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.rd_sel", rd_sel, 32'd0);
    chk("reset.fmt", 32'(fmt), 32'd0);
    chk("reset.wb_valid", 32'(wb_valid), 32'd0);
    chk("reset.wb_sel", wb_sel, 32'd0);
    reset_n = 1'b1;

    // Table-driven decode vectors
    for (int i = 0; i < 13; i++) begin
      ibus = vecs[i].ib; in_valid = vecs[i].v; stall = 1'b0; flush = 1'b0;
      step();
      chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d.rd_sel", i), rd_sel, vecs[i].rd);
      chk($sformatf("vec%0d.rn_sel", i), rn_sel, vecs[i].rn);
      chk($sformatf("vec%0d.rm_sel", i), rm_sel, vecs[i].rm);
      chk($sformatf("vec%0d.fmt", i), 32'(fmt), 32'(vecs[i].f));
      chk($sformatf("vec%0d.illegal", i), 32'(illegal), 32'(vecs[i].ill));
      chk($sformatf("vec%0d.z0_rd_sel", i), z_rd_sel, vecs[i].rd0);
      check_model($sformatf("vec%0d", i));
    end

    // STUR then bubbles: a valid writeback slot with an empty select
    ibus = 32'hF8000045; in_valid = 1'b1;
    step();
    idle(WB_LAT);
    chk("stur.wb_valid", 32'(wb_valid), 32'd1);
    chk("stur.wb_sel", wb_sel, 32'd0);

    // Nominal latency: ADD X3 reaches wb_sel WB_LAT clocks after capture
    idle(WB_LAT + 1);
    ibus = 32'h8B020023; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("lat.early_wb_valid", 32'(wb_valid), 32'd0);
    step();
    chk("lat.wb_valid", 32'(wb_valid), 32'd1);
    chk("lat.wb_sel", wb_sel, 32'h8);

    // Two stall cycles mid-delay push the writeback out to 5 clocks
    idle(WB_LAT + 1);
    ibus = 32'h8B020023; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    stall = 1'b1;
    step();
    check_model("stall1");
    step();
    check_model("stall2");
    chk("stall.rd_held", rd_sel, 32'h0);
    stall = 1'b0;
    step();
    chk("stall.early_wb_valid", 32'(wb_valid), 32'd0);
    step();
    chk("stall.wb_valid", 32'(wb_valid), 32'd1);
    chk("stall.wb_sel", wb_sel, 32'h8);

    // Flush with stall: decode register clears, delay line holds
    idle(WB_LAT + 1);
    ibus = 32'h8B020023; in_valid = 1'b1;
    step(); step();
    flush = 1'b1; stall = 1'b1;
    step();
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    chk("flush.rd_sel", rd_sel, 32'd0);
    chk("flush.rn_sel", rn_sel, 32'd0);
    chk("flush.rm_sel", rm_sel, 32'd0);
    check_model("flush_stall");
    flush = 1'b0; stall = 1'b0;
    for (int i = 0; i < WB_LAT + 1; i++) begin
      step();
      check_model("after_flush");
    end

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      int k;
      k = int'($urandom_range(0, NOPS + 3));
      if (k < NOPS) ibus = ($urandom & ~ops[k].mask) | ops[k].val;
      else          ibus = $urandom;
      in_valid = ($urandom_range(0, 9) < 8);
      stall    = ($urandom_range(0, 99) < 15);
      flush    = ($urandom_range(0, 99) < 10);
      step();
      check_model("rand");
    end

    // Asynchronous reset while a writeback is in flight
    stall = 1'b0; flush = 1'b0;
    ibus = 32'h8B020023; in_valid = 1'b1;
    for (int i = 0; i < WB_LAT + 1; i++) step();
    chk("arst.pre_wb_valid", 32'(wb_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.rd_sel", rd_sel, 32'd0);
    chk("arst.rn_sel", rn_sel, 32'd0);
    chk("arst.rm_sel", rm_sel, 32'd0);
    chk("arst.fmt", 32'(fmt), 32'd0);
    chk("arst.wb_valid", 32'(wb_valid), 32'd0);
    chk("arst.wb_sel", wb_sel, 32'd0);
    model_reset();
    @(negedge clk);
    in_valid = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < WB_LAT + 2; i++) begin
      step();
      chk("arst.no_wb_pulse", 32'(wb_valid), 32'd0);
      check_model("post_arst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
